fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end with a single-block line buffer.
// Fetches one BLOCK_W block from a synchronous instruction memory and feeds
// WORD_W instructions to decode over a valid/ready handshake.
// Optional macro FETCH_PERF_EN adds the perf_hits / perf_misses counters.
module fetch_unit #(
    parameter int                 WORD_W   = 32,
    parameter int                 BLOCK_W  = 128,
    parameter int                 MEM_LAT  = 1,
    parameter logic [WORD_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [WORD_W-1:0]  redirect_pc,
    output logic [WORD_W-1:0]  mem_addr,
    output logic               mem_req,
    input  logic [BLOCK_W-1:0] mem_data,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [WORD_W-1:0]  inst_out,
    output logic [WORD_W-1:0]  inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [WORD_W-1:0]  perf_hits,
    output logic [WORD_W-1:0]  perf_misses
`endif
);

    // Byte-offset bits inside one block.
    localparam int OFF_W = $clog2(BLOCK_W / 8);

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;

    localparam logic [WORD_W-1:0] BLK_MASK   = ~((WORD_W'(1) << OFF_W) - WORD_W'(1));
    localparam logic [WORD_W-1:0] ALIGN_MASK = ~WORD_W'(3);
    localparam logic [3:0]        LAT        = 4'(MEM_LAT);

    logic [0:0]         state_reg, state_next;
    logic [WORD_W-1:0]  pc_reg, pc_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic [WORD_W-1:0]  tag_reg;
    logic               buf_valid_reg, buf_valid_next;
    logic [BLOCK_W-1:0] buf_reg;

    logic               serving;
    logic               handshake;
    logic               redirect_hit;
    logic               capture;
    logic               fill_entry;
    logic               hit_event;
    logic [WORD_W-1:0]  pc_plus4;
    logic [BLOCK_W-1:0] buf_shifted;

    assign serving      = (state_reg == ST_SERVE);
    assign handshake    = serving & inst_ready & ~redirect;
    assign redirect_hit = buf_valid_reg && ((redirect_pc & BLK_MASK) == tag_reg);
    assign pc_plus4     = pc_reg + WORD_W'(4);
    assign capture      = ~redirect & ~serving & (cnt_reg == 4'd0);

    // Next-state selection: redirect first, then fill countdown, then sequential advance.
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        cnt_next       = cnt_reg;
        buf_valid_next = buf_valid_reg;
        fill_entry     = 1'b0;
        hit_event      = 1'b0;
        if (redirect) begin
            // A handshake presented this cycle is squashed; pc never advances.
            pc_next = redirect_pc & ALIGN_MASK;
            if (redirect_hit) begin
                state_next = ST_SERVE;
                hit_event  = 1'b1;
            end else begin
                state_next = ST_FILL;
                cnt_next   = LAT;
                fill_entry = 1'b1;
            end
        end else if (!serving) begin
            if (cnt_reg != 4'd0) begin
                cnt_next = cnt_reg - 4'd1;
            end else begin
                buf_valid_next = 1'b1;
                state_next     = ST_SERVE;
            end
        end else if (handshake) begin
            pc_next   = pc_plus4;
            hit_event = 1'b1;
            // Leaving the buffered block (including the last-word case) forces a refill.
            if ((pc_plus4 & BLK_MASK) != tag_reg) begin
                state_next = ST_FILL;
                cnt_next   = LAT;
                fill_entry = 1'b1;
            end
        end
    end

    // Control state with asynchronous reset; a reset mid-fill simply restarts the fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_FILL;
            pc_reg        <= RESET_PC & ALIGN_MASK;
            cnt_reg       <= LAT;
            buf_valid_reg <= 1'b0;
            tag_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            cnt_reg       <= cnt_next;
            buf_valid_reg <= buf_valid_next;
            if (capture) begin
                tag_reg <= pc_reg & BLK_MASK;
            end
        end
    end

    // Line buffer data; guarded by buf_valid so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture && !rst) begin
            buf_reg <= mem_data;
        end
    end

    // Byte 0 of the block lives in the MSBs, so shifting left by the byte offset
    // brings the addressed word to the top of the vector.
    always_comb begin
        buf_shifted = buf_reg << {pc_reg[OFF_W-1:0], 3'b000};
    end

    assign mem_addr   = pc_reg & BLK_MASK;
    assign mem_req    = ~serving;
    assign inst_valid = serving;
    assign inst_out   = serving ? buf_shifted[BLOCK_W-1 -: WORD_W] : '0;
    assign inst_pc    = pc_reg;

`ifdef FETCH_PERF_EN
    logic [WORD_W-1:0] hits_reg;
    logic [WORD_W-1:0] misses_reg;

    // Hit/miss counters; the reset-initiated fill is not a miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits_reg   <= '0;
            misses_reg <= '0;
        end else begin
            if (hit_event) begin
                hits_reg <= hits_reg + WORD_W'(1);
            end
            if (fill_entry) begin
                misses_reg <= misses_reg + WORD_W'(1);
            end
        end
    end

    assign perf_hits   = hits_reg;
    assign perf_misses = misses_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Expected PCs are queued as
// stimulus is driven and checked against every accepted instruction.
// Build with FETCH_PERF_EN defined to exercise the counters at MEM_LAT=3.
module tb_fetch_unit;

`ifdef FETCH_PERF_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic         clk;
    logic         rst;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic [31:0]  mem_addr;
    logic         mem_req;
    logic [127:0] mem_data;
    logic         inst_valid;
    logic         inst_ready;
    logic [31:0]  inst_out;
    logic [31:0]  inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0]  perf_hits;
    logic [31:0]  perf_misses;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    fetch_unit #(
        .WORD_W  (32),
        .BLOCK_W (128),
        .MEM_LAT (LAT),
        .RESET_PC(32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_data   (mem_data),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_hits  (perf_hits),
        .perf_misses(perf_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: byte[a] = a & 0xFF, first byte of a block in the MSBs.
    function automatic logic [127:0] block_of(input logic [31:0] a);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = 8'(a + 32'(i));
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        return {8'(pc), 8'(pc + 32'd1), 8'(pc + 32'd2), 8'(pc + 32'd3)};
    endfunction

    // Synchronous memory: data for an address appears LAT clocks later.
    logic [127:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= block_of(mem_addr);
        for (int k = 1; k < LAT; k++) begin
            pipe[k] <= pipe[k-1];
        end
    end
    assign mem_data = pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted, non-squashed instruction is popped and compared.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && inst_valid && inst_ready && !redirect) begin
            check("accept_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                $display("accept pc=%h inst=%h (expected pc=%h inst=%h)", inst_pc, inst_out, e, exp_word(e));
                check("inst_pc", inst_pc, e);
                check("inst_out", inst_out, exp_word(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Follows a fill to its end: counts mem_req cycles and checks the address is stable.
    task automatic wait_fill(input logic [31:0] addr, input string tag);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (inst_valid) begin
                done = 1'b1;
            end else begin
                if (mem_req) n++;
                check({tag, "_addr"}, mem_addr, addr);
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_len"}, 32'(n), 32'(LAT + 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_out", inst_out, 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_req", 32'(mem_req), 32'd1);
        check("rst_addr", mem_addr, 32'h0);
`ifdef FETCH_PERF_EN
        check("rst_hits", perf_hits, 32'd0);
        check("rst_misses", perf_misses, 32'd0);
`endif

        // Sequential stream from reset across a block boundary.
        tick();
        rst = 1'b0;
        inst_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        exp_q.push_back(32'h10);
        wait_fill(32'h0, "fill0");
        repeat (3) begin
            @(negedge clk);
            check("seq_valid", 32'(inst_valid), 32'd1);
        end
        wait_fill(32'h10, "fill10");
        tick();
        inst_ready = 1'b0;
        @(negedge clk);
`ifdef FETCH_PERF_EN
        check("perf_hits_seq", perf_hits, 32'd5);
        check("perf_misses_seq", perf_misses, 32'd1);
`endif

        // Stall: outputs hold, no refill.
        repeat (5) begin
            @(negedge clk);
            check("stall_pc", inst_pc, 32'h14);
            check("stall_out", inst_out, 32'h14151617);
            check("stall_req", 32'(mem_req), 32'd0);
        end

        // Redirect inside the buffered block, with a squashed handshake.
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h1B;
        inst_ready = 1'b1;
        tick();
        redirect = 1'b0;
        inst_ready = 1'b0;
        @(negedge clk);
        check("rhit_valid", 32'(inst_valid), 32'd1);
        check("rhit_pc", inst_pc, 32'h18);
        check("rhit_out", inst_out, 32'h18191A1B);
        check("rhit_req", 32'(mem_req), 32'd0);

        // Redirect to another block.
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h114;
        inst_ready = 1'b1;
        exp_q.push_back(32'h114);
        tick();
        redirect = 1'b0;
        wait_fill(32'h110, "fill110");
        tick();
        inst_ready = 1'b0;
        @(negedge clk);
        check("after114_pc", inst_pc, 32'h118);

        // Redirect on the second cycle of a fill aborts it.
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h10;
        tick();
        redirect = 1'b0;
        tick();
        check("abort_addr", mem_addr, 32'h10);
        redirect = 1'b1;
        redirect_pc = 32'h40;
        inst_ready = 1'b1;
        exp_q.push_back(32'h40);
        tick();
        redirect = 1'b0;
        wait_fill(32'h40, "fill40");
        tick();
        inst_ready = 1'b0;
        @(negedge clk);
`ifdef FETCH_PERF_EN
        check("perf_hits_end", perf_hits, 32'd8);
        check("perf_misses_end", perf_misses, 32'd4);
`endif

        // Asynchronous reset in the middle of a fill.
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        #2;
        check("prerst_addr", mem_addr, 32'h80);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(inst_valid), 32'd0);
        check("midrst_out", inst_out, 32'h0);
        check("midrst_pc", inst_pc, 32'h0);
        check("midrst_addr", mem_addr, 32'h0);
        check("midrst_req", 32'(mem_req), 32'd1);
`ifdef FETCH_PERF_EN
        check("midrst_hits", perf_hits, 32'd0);
        check("midrst_misses", perf_misses, 32'd0);
`endif
        tick();
        rst = 1'b0;
        wait_fill(32'h0, "fill_rst");
        check("postrst_pc", inst_pc, 32'h0);
        check("postrst_out", inst_out, 32'h00010203);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
